snoop_memory: RTL



---
 rtl/snoop_pkg.sv | 27 ++
 rtl/snoop_mem_array.sv | 29 ++
 rtl/snoop_memory.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/snoop_pkg.sv
// Shared definitions for the snooping memory and the cache controllers:
// bus op codes, memory FSM state encoding and bus field widths.
package snoop_pkg;

  // Width of the op field at the top of every bus message
  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    READ_MISS  = 2'd0,
    WRITE_BACK = 2'd1,
    WRITE_MISS = 2'd2,
    INVALIDATE = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  // Total bus message width for a given tag/data split
  function automatic int bus_width(input int tag_w, input int data_w);
    return OP_W + tag_w + data_w;
  endfunction

endpackage

// File: rtl/snoop_mem_array.sv
// Plain storage for the snooping memory: one synchronous write port and
// one combinational read port. No reset; contents are cleared by the
// controller's INIT sweep.
module snoop_mem_array #(
  parameter int DATA_W = 4,
  parameter int TAG_W  = 3,
  parameter int DEPTH  = 7
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [TAG_W-1:0]  i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [TAG_W-1:0]  i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Write port: the controller guarantees the address is below DEPTH
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Out-of-range reads are masked by the controller
  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/snoop_memory.sv
// Snooping main memory: accepts bus messages in IDLE, services write-backs
// immediately and answers read/write misses after a fixed latency.
module snoop_memory
  import snoop_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int TAG_W   = 3,
  parameter int DEPTH   = 7,
  parameter int LATENCY = 2
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           bus_valid,
  input  logic [OP_W+TAG_W+DATA_W-1:0]   bus,
  output logic                           bus_ready,
  output logic                           mem_valid,
  output logic [DATA_W-1:0]              memOut,
  output logic [TAG_W-1:0]               mem_tag,
  output logic                           mem_err
);

  // Wait counter only needs to reach LATENCY-2
  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;

  state_e              r_state;
  logic [TAG_W-1:0]    r_init_idx;
  logic [CNT_W-1:0]    r_wait_cnt;
  logic                r_bus_ready;
  logic                r_mem_valid;
  logic [DATA_W-1:0]   r_mem_out;
  logic [TAG_W-1:0]    r_mem_tag;
  logic                r_mem_err;
  logic [TAG_W-1:0]    r_lat_tag;
  logic [DATA_W-1:0]   r_lat_data;
  logic                r_lat_err;

  op_e                 w_op;
  logic [TAG_W-1:0]    w_tag;
  logic [DATA_W-1:0]   w_data;
  logic                w_in_range;
  logic                w_accept;
  logic [DATA_W-1:0]   w_rd_data;
  logic [DATA_W-1:0]   w_rd_masked;
  logic                w_wr_en;
  logic [TAG_W-1:0]    w_wr_addr;
  logic [DATA_W-1:0]   w_wr_data;

  assign w_op        = op_e'(bus[TAG_W+DATA_W +: OP_W]);
  assign w_tag       = bus[DATA_W +: TAG_W];
  assign w_data      = bus[DATA_W-1:0];
  assign w_in_range  = ({1'b0, w_tag} < (TAG_W+1)'(DEPTH));
  assign w_accept    = bus_valid & r_bus_ready;
  assign w_rd_masked = w_in_range ? w_rd_data : '0;

  // Write port steering: INIT sweep zeroes words, IDLE takes in-range write-backs
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = w_tag;
    w_wr_data = w_data;
    if (r_state == INIT) begin
      w_wr_en   = 1'b1;
      w_wr_addr = r_init_idx;
      w_wr_data = '0;
    end else if (w_accept && (w_op == WRITE_BACK) && w_in_range) begin
      w_wr_en = 1'b1;
    end
  end

  snoop_mem_array #(
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .i_clk     (clock),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (w_wr_data),
    .i_rd_addr (w_tag),
    .o_rd_data (w_rd_data)
  );

  // Control FSM with registered bus/response outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= INIT;
      r_init_idx  <= '0;
      r_wait_cnt  <= '0;
      r_bus_ready <= 1'b0;
      r_mem_valid <= 1'b0;
      r_mem_out   <= '0;
      r_mem_tag   <= '0;
      r_mem_err   <= 1'b0;
      r_lat_tag   <= '0;
      r_lat_data  <= '0;
      r_lat_err   <= 1'b0;
    end else begin
      // Both strobes are single-cycle unless re-asserted below
      r_mem_valid <= 1'b0;
      r_mem_err   <= 1'b0;
      case (r_state)
        INIT: begin
          if (r_init_idx == TAG_W'(DEPTH-1)) begin
            r_state     <= IDLE;
            r_bus_ready <= 1'b1;
          end else begin
            r_init_idx <= r_init_idx + 1'b1;
          end
        end
        IDLE: begin
          if (w_accept) begin
            case (w_op)
              WRITE_BACK: begin
                // In-range data is written by the steering logic; only flag bad tags
                if (!w_in_range) begin
                  r_mem_err <= 1'b1;
                end
              end
              READ_MISS, WRITE_MISS: begin
                r_lat_tag   <= w_tag;
                r_lat_data  <= w_rd_masked;
                r_lat_err   <= ~w_in_range;
                r_wait_cnt  <= '0;
                r_bus_ready <= 1'b0;
                if (LATENCY > 1) begin
                  r_state <= WAIT;
                end else begin
                  r_state     <= RESP;
                  r_mem_valid <= 1'b1;
                  r_mem_out   <= w_rd_masked;
                  r_mem_tag   <= w_tag;
                  r_mem_err   <= ~w_in_range;
                end
              end
              default: begin
                // INVALIDATE: nothing to do in memory
              end
            endcase
          end
        end
        WAIT: begin
          if (r_wait_cnt == CNT_W'(LATENCY-2)) begin
            r_state     <= RESP;
            r_mem_valid <= 1'b1;
            r_mem_out   <= r_lat_data;
            r_mem_tag   <= r_lat_tag;
            r_mem_err   <= r_lat_err;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        RESP: begin
          r_state     <= IDLE;
          r_bus_ready <= 1'b1;
        end
        default: begin
          r_state     <= INIT;
          r_bus_ready <= 1'b0;
        end
      endcase
    end
  end

  assign bus_ready = r_bus_ready;
  assign mem_valid = r_mem_valid;
  assign memOut    = r_mem_out;
  assign mem_tag   = r_mem_tag;
  assign mem_err   = r_mem_err;

endmodule
